// File: rtl/dram_bus_pkg.sv
// Shared definitions for the dual-master data-RAM / MMIO arbiter:
// MMIO register addresses, arbiter FSM states and bus-owner identifiers.
package dram_bus_pkg;

    localparam logic [31:0] LED_LO = 32'hFFFF_F060;
    localparam logic [31:0] LED_HI = 32'hFFFF_F062;
    localparam logic [31:0] SW_LO  = 32'hFFFF_F070;
    localparam logic [31:0] SW_HI  = 32'hFFFF_F072;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_t;

    // The master that is not o; used to advance the round-robin pointer.
    function automatic owner_t other_owner(input owner_t o);
        return (o == OWN_M0) ? OWN_M1 : OWN_M0;
    endfunction

endpackage

// File: rtl/dram_bus_arbiter_mmio_dev_regs.sv
// LED/switch MMIO window: exact-match address decode, the 24-bit LED
// register bank and the read mux for LED and switch values.
module mmio_dev_regs
    import dram_bus_pkg::*;
#(
    parameter int          ADDR_W  = 32,
    parameter int          DATA_W  = 32,
    parameter logic [23:0] LED_RST = 24'h000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_adr,
    input  logic              i_wr,
    input  logic [15:0]       i_wdata,
    input  logic [23:0]       i_sw,
    output logic              o_is_mmio,
    output logic [DATA_W-1:0] o_rd_mmio,
    output logic [23:0]       o_led
);

    logic        w_hit_led_lo;
    logic        w_hit_led_hi;
    logic        w_hit_sw_lo;
    logic        w_hit_sw_hi;
    logic [23:0] r_led;

    assign w_hit_led_lo = (i_adr == ADDR_W'(LED_LO));
    assign w_hit_led_hi = (i_adr == ADDR_W'(LED_HI));
    assign w_hit_sw_lo  = (i_adr == ADDR_W'(SW_LO));
    assign w_hit_sw_hi  = (i_adr == ADDR_W'(SW_HI));

    // Switch addresses count as MMIO too so that writes to them never reach RAM.
    assign o_is_mmio = w_hit_led_lo | w_hit_led_hi | w_hit_sw_lo | w_hit_sw_hi;
    assign o_led     = r_led;

    // LED bank: low half-word or high byte updated by a qualified write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led <= LED_RST;
        end else if (i_wr && w_hit_led_lo) begin
            r_led[15:0] <= i_wdata;
        end else if (i_wr && w_hit_led_hi) begin
            r_led[23:16] <= i_wdata[7:0];
        end
    end

    // Read mux: zero-extended LED/switch fields, zero for non-MMIO addresses.
    always_comb begin
        o_rd_mmio = '0;
        if (w_hit_led_lo) begin
            o_rd_mmio = DATA_W'(r_led[15:0]);
        end else if (w_hit_led_hi) begin
            o_rd_mmio = DATA_W'(r_led[23:16]);
        end else if (w_hit_sw_lo) begin
            o_rd_mmio = DATA_W'(i_sw[15:0]);
        end else if (w_hit_sw_hi) begin
            o_rd_mmio = DATA_W'(i_sw[23:16]);
        end
    end

endmodule

// File: rtl/dram_bus_arbiter.sv
// Two-master arbiter for the data-RAM port and the LED/switch MMIO window.
// Master 0 is the CPU data port, master 1 the debug/program loader.
// Each access runs IDLE/RESP -> ACCESS -> RESP, giving one access per two
// cycles with re-arbitration in RESP.
// Build option: define ARB_RR_EN for round-robin arbitration; without it
// master 0 has fixed priority and master 1 may starve.
module dram_bus_arbiter
    import dram_bus_pkg::*;
#(
    parameter int          DATA_W  = 32,
    parameter int          ADDR_W  = 32,
    parameter int          RAM_AW  = 14,
    parameter logic [23:0] LED_RST = 24'h000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_adr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_adr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [RAM_AW-1:0] ram_a,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_d,
    input  logic [DATA_W-1:0] ram_spo,
    input  logic [23:0]       device_sw,
    output logic [23:0]       device_led
);

    state_t            r_state;
    state_t            w_state_nxt;
    owner_t            r_owner;
    owner_t            w_win;
    logic [ADDR_W-1:0] r_adr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic              w_any_req;
    logic              w_latch;
    logic              w_is_mmio;
    logic              w_mmio_wr;
    logic [DATA_W-1:0] w_rd_mmio;
    logic [DATA_W-1:0] w_rd_mux;

    assign w_any_req = m0_req | m1_req;

`ifdef ARB_RR_EN
    owner_t r_rr_ptr;

    // Winner selection: the pointer breaks ties, a lone requester always wins.
    always_comb begin
        w_win = OWN_M0;
        if (m0_req && m1_req) begin
            w_win = r_rr_ptr;
        end else if (m1_req) begin
            w_win = OWN_M1;
        end
    end

    // Round-robin pointer hands priority to the loser after every grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= OWN_M0;
        end else if (w_latch) begin
            r_rr_ptr <= other_owner(w_win);
        end
    end
`else
    // Winner selection: master 0 always has priority.
    always_comb begin
        w_win = m0_req ? OWN_M0 : OWN_M1;
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus grant/valid pulses and the gated RAM write strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        m0_gnt      = 1'b0;
        m1_gnt      = 1'b0;
        m0_rvalid   = 1'b0;
        m1_rvalid   = 1'b0;
        ram_we      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                m0_gnt      = (r_owner == OWN_M0);
                m1_gnt      = (r_owner == OWN_M1);
                ram_we      = r_we && !w_is_mmio;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                m0_rvalid = (r_owner == OWN_M0);
                m1_rvalid = (r_owner == OWN_M1);
                if (w_any_req) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Owner id of the access in flight; cleared so gnt/rvalid decode is defined.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= OWN_M0;
        end else if (w_latch) begin
            r_owner <= w_win;
        end
    end

    // Command latch: the winner's address, direction and write data.
    always_ff @(posedge clk) begin
        if (w_latch) begin
            r_adr   <= (w_win == OWN_M1) ? m1_adr   : m0_adr;
            r_we    <= (w_win == OWN_M1) ? m1_we    : m0_we;
            r_wdata <= (w_win == OWN_M1) ? m1_wdata : m0_wdata;
        end
    end

    assign ram_a     = r_adr[RAM_AW+1:2];
    assign ram_d     = r_wdata;
    assign w_mmio_wr = (r_state == ST_ACCESS) && r_we;
    assign w_rd_mux  = w_is_mmio ? w_rd_mmio : ram_spo;

    // Read data capture at the end of ACCESS into the owning master's register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else if (r_state == ST_ACCESS) begin
            if (r_owner == OWN_M0) begin
                m0_rdata <= w_rd_mux;
            end else begin
                m1_rdata <= w_rd_mux;
            end
        end
    end

    mmio_dev_regs #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .LED_RST (LED_RST)
    ) u_mmio (
        .clk       (clk),
        .rst       (rst),
        .i_adr     (r_adr),
        .i_wr      (w_mmio_wr),
        .i_wdata   (r_wdata[15:0]),
        .i_sw      (device_sw),
        .o_is_mmio (w_is_mmio),
        .o_rd_mmio (w_rd_mmio),
        .o_led     (device_led)
    );

endmodule

// File: tb/tb_dram_bus_arbiter.sv
// Scoreboard bench for dram_bus_arbiter: drivers push expected responses
// from a behavioural memory/LED/switch model; a negedge monitor pops and
// compares on rvalid and checks RAM strobes on gnt.
module tb_dram_bus_arbiter;

    localparam logic [31:0] A_LED_LO = 32'hFFFF_F060;
    localparam logic [31:0] A_LED_HI = 32'hFFFF_F062;
    localparam logic [31:0] A_SW_LO  = 32'hFFFF_F070;
    localparam logic [31:0] A_SW_HI  = 32'hFFFF_F072;

    logic        clk, rst;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [31:0] m0_adr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [31:0] m1_adr, m1_wdata, m1_rdata;
    logic [13:0] ram_a;
    logic        ram_we;
    logic [31:0] ram_d, ram_spo;
    logic [23:0] device_sw, device_led;

    dram_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_a(ram_a), .ram_we(ram_we), .ram_d(ram_d), .ram_spo(ram_spo),
        .device_sw(device_sw), .device_led(device_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dram core stand-in: asynchronous read, write on the rising edge
    logic [31:0] ram [0:16383];
    assign ram_spo = ram[ram_a];
    always @(posedge clk) if (ram_we) ram[ram_a] <= ram_d;

    typedef struct packed {
        logic        ram_wr;
        logic [13:0] ra;
        logic [31:0] rdata;
    } txn_t;

    txn_t        q0[$];
    txn_t        q1[$];
    int          glog[$];
    int          last_gnt;
    int          checks;
    int          failures;
    logic [31:0] mdl_mem [int];
    logic [23:0] mdl_led;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endfunction

    function automatic bit is_mmio(input logic [31:0] adr);
        return (adr == A_LED_LO) || (adr == A_LED_HI) || (adr == A_SW_LO) || (adr == A_SW_HI);
    endfunction

    // Returns what the access reads (value before any write) and applies the write.
    function automatic logic [31:0] model_access(input bit we, input logic [31:0] adr, input logic [31:0] wd);
        logic [31:0] r;
        int          w;
        w = int'(adr[15:2]);
        case (adr)
            A_LED_LO: r = {16'h0, mdl_led[15:0]};
            A_LED_HI: r = {24'h0, mdl_led[23:16]};
            A_SW_LO:  r = {16'h0, device_sw[15:0]};
            A_SW_HI:  r = {24'h0, device_sw[23:16]};
            default:  r = mdl_mem.exists(w) ? mdl_mem[w] : 32'h0;
        endcase
        if (we) begin
            if (adr == A_LED_LO) mdl_led[15:0] = wd[15:0];
            else if (adr == A_LED_HI) mdl_led[23:16] = wd[7:0];
            else if (!is_mmio(adr)) mdl_mem[w] = wd;
        end
        return r;
    endfunction

    function automatic int qsize(input int m);
        return (m == 0) ? q0.size() : q1.size();
    endfunction

    function automatic txn_t qfront(input int m);
        return (m == 0) ? q0[0] : q1[0];
    endfunction

    function automatic txn_t qpop(input int m);
        return (m == 0) ? q0.pop_front() : q1.pop_front();
    endfunction

    // Monitor: compares DUT outputs against queued expectations
    bit pg [2];
    always @(negedge clk) begin
        logic [1:0]  gnt, rv;
        logic [31:0] rd [2];
        txn_t        t;
        gnt = {m1_gnt, m0_gnt};
        rv  = {m1_rvalid, m0_rvalid};
        rd[0] = m0_rdata;
        rd[1] = m1_rdata;
        if (rst) begin
            pg[0] = 1'b0;
            pg[1] = 1'b0;
        end else begin
            if (gnt != 2'b00) check("gnt_exclusive", 32'(gnt[0] & gnt[1]), 32'h0);
            if (gnt == 2'b00) check("ram_we_outside_access", 32'(ram_we), 32'h0);
            for (int m = 0; m < 2; m++) begin
                if (pg[m] || rv[m]) check($sformatf("m%0d_rvalid_after_gnt", m), 32'(rv[m]), 32'(pg[m]));
                if (rv[m]) begin
                    if (qsize(m) == 0) begin
                        check($sformatf("m%0d_unexpected_rvalid", m), 32'h1, 32'h0);
                    end else begin
                        t = qpop(m);
                        check($sformatf("m%0d_rdata", m), rd[m], t.rdata);
                    end
                end
                if (gnt[m]) begin
                    glog.push_back(m);
                    last_gnt = m;
                    if (qsize(m) == 0) begin
                        check($sformatf("m%0d_unexpected_gnt", m), 32'h1, 32'h0);
                    end else begin
                        t = qfront(m);
                        check($sformatf("m%0d_ram_we", m), 32'(ram_we), 32'(t.ram_wr));
                        if (t.ram_wr) check($sformatf("m%0d_ram_a", m), 32'(ram_a), 32'(t.ra));
                    end
                end
                pg[m] = gnt[m];
            end
        end
    end

    // One access: model the result, queue it, raise req and wait for gnt.
    task automatic issue(input int m, input bit we, input logic [31:0] adr,
                         input logic [31:0] wd, input bit hold, output int waited);
        txn_t t;
        int   n;
        t.ram_wr = we && !is_mmio(adr);
        t.ra     = adr[15:2];
        t.rdata  = model_access(we, adr, wd);
        if (m == 0) begin
            m0_we = we; m0_adr = adr; m0_wdata = wd; q0.push_back(t); m0_req = 1'b1;
        end else begin
            m1_we = we; m1_adr = adr; m1_wdata = wd; q1.push_back(t); m1_req = 1'b1;
        end
        waited = -1;
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if ((m == 0) ? m0_gnt : m1_gnt) begin
                waited = n;
                break;
            end
        end
        if (waited < 0) begin
            check($sformatf("m%0d_gnt_timeout", m), 32'h0, 32'h1);
            if (m == 0) void'(q0.pop_back()); else void'(q1.pop_back());
            hold = 1'b0;
        end
        if (!hold) begin
            if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            check("rvalid_timeout", 32'(q0.size() + q1.size()), 32'h0);
            q0.delete();
            q1.delete();
        end
        @(negedge clk);
    endtask

    task automatic single(input int m, input bit we, input logic [31:0] adr, input logic [31:0] wd);
        int w;
        issue(m, we, adr, wd, 1'b0, w);
        wait_idle();
    endtask

    // Back-to-back stream with req held across grants; reports the longest wait.
    task automatic run_stream(input int m, input int n, input logic [31:0] base, output int maxw);
        int w;
        maxw = 0;
        for (int i = 0; i < n; i++) begin
            issue(m, 1'(i & 1), base + 32'(4 * i), $urandom, (i < n - 1), w);
            if (w > maxw) maxw = w;
        end
    endtask

    task automatic run_random(input int m, input int n);
        int          w, r;
        bit          we, hold;
        logic [31:0] adr;
        for (int i = 0; i < n; i++) begin
            r  = $urandom_range(0, 9);
            we = 1'($urandom_range(0, 1));
            if (r < 6) adr = ((m == 0) ? 32'h1000 : 32'h2000) + 32'(4 * $urandom_range(0, 15));
            else if (m == 0 && r == 6) adr = A_LED_LO;
            else if (m == 0 && r == 7) adr = A_LED_HI;
            else adr = r[0] ? A_SW_HI : A_SW_LO;
            hold = (i < n - 1) && ($urandom_range(0, 1) == 1);
            issue(m, we, adr, $urandom, hold, w);
            if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        int w, w0, w1, first;
        txn_t t;
        checks = 0; failures = 0;
        last_gnt = 1;
        mdl_led = 24'h0;
        m0_req = 0; m0_we = 0; m0_adr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_adr = 0; m1_wdata = 0;
        device_sw = 24'h0;
        for (int i = 0; i < 16384; i++) ram[i] = 32'h0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_m0_gnt", 32'(m0_gnt), 32'h0);
        check("rst_m1_rvalid", 32'(m1_rvalid), 32'h0);
        check("rst_ram_we", 32'(ram_we), 32'h0);
        check("rst_led", 32'(device_led), 32'h0);
        check("rst_m0_rdata", m0_rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // write then read back through RAM
        single(0, 1'b1, 32'h100, 32'h1234_5678);
        issue(0, 1'b0, 32'h100, 32'h0, 1'b0, w);
        check("t1_gnt_latency", 32'(w), 32'h1);
        wait_idle();
        check("t1_readback", m0_rdata, 32'h1234_5678);

        // both masters stream 4 accesses each
        glog.delete();
        first = (last_gnt == 0) ? 1 : 0;
        fork
            run_stream(0, 4, 32'h400, w0);
            run_stream(1, 4, 32'h800, w1);
        join
        wait_idle();
        check("t2_grant_count", 32'(glog.size()), 32'h8);
        for (int i = 0; i < 8 && i < glog.size(); i++) begin
`ifdef ARB_RR_EN
            check($sformatf("t2_rr_grant%0d", i), 32'(glog[i]), 32'(first ^ (i & 1)));
`else
            check($sformatf("t3_fixed_grant%0d", i), 32'(glog[i]), (i < 4) ? 32'h0 : 32'h1);
`endif
        end
`ifdef ARB_RR_EN
        check("t2_m0_wait_le4", 32'(w0 <= 4), 32'h1);
        check("t2_m1_wait_le4", 32'(w1 <= 4), 32'h1);
`endif

        // LED writes and readback
        single(0, 1'b1, A_LED_LO, 32'h0000_ABCD);
        single(0, 1'b1, A_LED_HI, 32'h0000_005A);
        check("t4_led", 32'(device_led), 32'h005A_ABCD);
        single(0, 1'b0, A_LED_LO, 32'h0);
        check("t4_led_lo_read", m0_rdata, 32'h0000_ABCD);
        single(1, 1'b0, A_LED_HI, 32'h0);
        check("t4_led_hi_read", m1_rdata, 32'h0000_005A);

        // switch reads; switch writes dropped
        device_sw = 24'hC3F00F;
        @(negedge clk);
        fork
            single(0, 1'b0, A_SW_LO, 32'h0);
            single(1, 1'b0, A_SW_HI, 32'h0);
        join
        check("t5_sw_lo", m0_rdata, 32'h0000_F00F);
        check("t5_sw_hi", m1_rdata, 32'h0000_00C3);
        single(0, 1'b1, A_SW_LO, 32'hFFFF_FFFF);
        check("t5_led_unchanged", 32'(device_led), 32'h005A_ABCD);
        check("t5_ram_untouched", ram[A_SW_LO[15:2]], 32'h0);

        // reset during the ACCESS cycle of a RAM write
        single(0, 1'b1, 32'h200, 32'hCAFE_F00D);
        t.ram_wr = 1'b1; t.ra = 14'h80; t.rdata = 32'h0;
        q0.push_back(t);
        m0_we = 1'b1; m0_adr = 32'h200; m0_wdata = 32'hDEAD_0000; m0_req = 1'b1;
        w = 0;
        while (!m0_gnt && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("t6_saw_gnt", 32'(m0_gnt), 32'h1);
        rst = 1'b1;
        #1;
        check("t6_ram_we", 32'(ram_we), 32'h0);
        check("t6_gnt", 32'(m0_gnt), 32'h0);
        check("t6_led", 32'(device_led), 32'h0);
        check("t6_rdata", m0_rdata, 32'h0);
        m0_req = 1'b0;
        q0.delete();
        mdl_led = 24'h0;
        last_gnt = 1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("t6_idle_gnt", 32'({m1_gnt, m0_gnt}), 32'h0);
        check("t6_idle_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'h0);
        single(0, 1'b0, 32'h200, 32'h0);
        check("t6_ram_kept", m0_rdata, 32'hCAFE_F00D);

        // randomized concurrent traffic
        fork
            run_random(0, 30);
            run_random(1, 30);
        join
        wait_idle();
        check("rand_led", 32'(device_led), 32'(mdl_led));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
